memory_arbiter: RTL and testbench

Two-port round-robin arbiter that shares one single-port word memory between an instruction-fetch requester (port 0) and a load/store requester (port 1). It sits between the core's request ports and the memory's rd_en/wr_en/addr/data/ack interface. It serialises transactions, holds the memory enables until the memory acknowledges, and inserts a drain cycle so a lingering memory ack is never credited to the next transaction. A watchdog turns a missing memory ack into an error response.

---
 rtl/memory_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_memory_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_arbiter.sv
`timescale 1ns/1ps
// memory_arbiter
// Two-port round-robin arbiter that shares one single-port word memory
// between an instruction-fetch requester (port 0) and a load/store requester
// (port 1). Each transaction goes IDLE -> BUSY -> DRAIN. Memory enables are
// held from registers until the memory acknowledges. A one-cycle DRAIN follows
// every transaction so that the memory's lingering ack is never credited to
// the next one. A watchdog turns a missing memory ack into an error response.
//
// Ports
//   clk, rst_n             clock; synchronous active-low reset
//   pN_req_i               port N request, held stable until pN_ack_o
//   pN_we_i                port N direction (1 = write)
//   pN_addr_i, pN_data_i   port N byte address and write data
//   pN_data_o              port N read data, registered, held between acks
//   pN_ack_o, pN_err_o     one-cycle completion pulse; err = watchdog timeout
//   mem_rd_en_o/wr_en_o    memory enables (never both high)
//   mem_addr_o, mem_data_o memory address / write data (hold outside BUSY)
//   mem_data_i, mem_ack_i  memory read data and acknowledge
module memory_arbiter #(
  parameter int unsigned TIMEOUT = 32'd15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        p0_req_i,
  input  logic        p0_we_i,
  input  logic [31:0] p0_addr_i,
  input  logic [31:0] p0_data_i,
  output logic [31:0] p0_data_o,
  output logic        p0_ack_o,
  output logic        p0_err_o,
  input  logic        p1_req_i,
  input  logic        p1_we_i,
  input  logic [31:0] p1_addr_i,
  input  logic [31:0] p1_data_i,
  output logic [31:0] p1_data_o,
  output logic        p1_ack_o,
  output logic        p1_err_o,
  output logic        mem_rd_en_o,
  output logic        mem_wr_en_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  input  logic [31:0] mem_data_i,
  input  logic        mem_ack_i
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Watchdog fires in the BUSY cycle whose count equals this value.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 32'd1);

  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic        port_q, port_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        rd_en_q, rd_en_d;
  logic        wr_en_q, wr_en_d;
  logic [1:0]  ack_q, ack_d;
  logic [1:0]  err_q, err_d;
  logic [31:0] data0_q, data0_d;
  logic [31:0] data1_q, data1_d;

  logic        sel_s;
  logic        sel_we_s;
  logic [31:0] sel_addr_s;
  logic [31:0] sel_wdata_s;

  // Candidate grant: the lone requester, or on a tie the port not granted last.
  assign sel_s       = (p0_req_i && p1_req_i) ? ~last_q : p1_req_i;
  assign sel_we_s    = sel_s ? p1_we_i   : p0_we_i;
  assign sel_addr_s  = sel_s ? p1_addr_i : p0_addr_i;
  assign sel_wdata_s = sel_s ? p1_data_i : p0_data_i;

  // Next-state and registered-output logic for the IDLE/BUSY/DRAIN sequencer.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    port_d  = port_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rd_en_d = rd_en_q;
    wr_en_d = wr_en_q;
    ack_d   = 2'b00;
    err_d   = 2'b00;
    data0_d = data0_q;
    data1_d = data1_q;

    case (state_q)
      IDLE: begin
        if (p0_req_i || p1_req_i) begin
          port_d  = sel_s;
          last_d  = sel_s;
          we_d    = sel_we_s;
          addr_d  = sel_addr_s;
          wdata_d = sel_wdata_s;
          cnt_d   = 8'd0;
          rd_en_d = ~sel_we_s;
          wr_en_d = sel_we_s;
          state_d = BUSY;
        end else begin
          state_d = IDLE;
        end
      end

      BUSY: begin
        cnt_d = cnt_q + 8'd1;
        if (mem_ack_i) begin
          rd_en_d        = 1'b0;
          wr_en_d        = 1'b0;
          ack_d[port_q]  = 1'b1;
          state_d        = DRAIN;
          // mem_data_i is only valid now, so capture it into the granted port.
          if (!we_q && port_q) begin
            data1_d = mem_data_i;
          end else if (!we_q) begin
            data0_d = mem_data_i;
          end else begin
            data0_d = data0_q;
          end
        end else if (cnt_q == CNT_LAST) begin
          rd_en_d        = 1'b0;
          wr_en_d        = 1'b0;
          ack_d[port_q]  = 1'b1;
          err_d[port_q]  = 1'b1;
          state_d        = DRAIN;
          // A timed-out read returns zero; a timed-out write leaves data_o alone.
          if (!we_q && port_q) begin
            data1_d = 32'd0;
          end else if (!we_q) begin
            data0_d = 32'd0;
          end else begin
            data0_d = data0_q;
          end
        end else begin
          state_d = BUSY;
        end
      end

      DRAIN: begin
        // The memory's ack may still be high here; it is deliberately ignored.
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        rd_en_d = 1'b0;
        wr_en_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;  // "port 1 granted last" makes port 0 win the first tie
      port_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      cnt_q   <= 8'd0;
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      ack_q   <= 2'b00;
      err_q   <= 2'b00;
      data0_q <= 32'd0;
      data1_q <= 32'd0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      port_q  <= port_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rd_en_q <= rd_en_d;
      wr_en_q <= wr_en_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      data0_q <= data0_d;
      data1_q <= data1_d;
    end
  end

  assign p0_data_o   = data0_q;
  assign p1_data_o   = data1_q;
  assign p0_ack_o    = ack_q[0];
  assign p1_ack_o    = ack_q[1];
  assign p0_err_o    = err_q[0];
  assign p1_err_o    = err_q[1];
  assign mem_rd_en_o = rd_en_q;
  assign mem_wr_en_o = wr_en_q;
  assign mem_addr_o  = addr_q;
  assign mem_data_o  = wdata_q;

endmodule

// File: tb/tb_memory_arbiter.sv
`timescale 1ns/1ps
// Bench for memory_arbiter: table-driven transactions, hand-written corner
// sequences and a randomized run, all compared every cycle against a
// transaction-level reference model (grant order from the round-robin rule,
// completion time from fixed latencies, data from a shadow memory).
module tb_memory_arbiter;

  localparam int unsigned TO = 4;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  typedef struct {
    int          port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk_data;
    logic [31:0] exp_data;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        p0_req = 1'b0, p0_we = 1'b0;
  logic [31:0] p0_addr = 32'd0, p0_wdata = 32'd0;
  logic        p1_req = 1'b0, p1_we = 1'b0;
  logic [31:0] p1_addr = 32'd0, p1_wdata = 32'd0;
  logic [31:0] p0_data, p1_data;
  logic        p0_ack, p0_err, p1_ack, p1_err;
  logic        mem_rd_en, mem_wr_en;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack = 1'b0;
  logic        mem_noack = 1'b0;
  logic [31:0] ram [0:255];

  int n_vec = 0;
  int n_err = 0;

  // Transaction queues feeding the two requesters.
  txn_t q0[$];
  txn_t q1[$];

  // Reference model state.
  int          cyc = 0;
  int          m_free = 0;
  int          m_ack_cyc = -1;
  int          m_en_lo = -1;
  int          m_en_hi = -2;
  int          m_port = 0;
  int          m_last = 1;
  logic        m_we_l = 1'b0;
  logic        m_err_pend = 1'b0;
  logic [31:0] m_rd_pend = 32'd0;
  logic [31:0] m_addr = 32'd0;
  logic [31:0] m_wdata = 32'd0;
  logic [31:0] m_data [0:1] = '{32'd0, 32'd0};
  logic [31:0] m_mem [0:255];

  // Observed completions.
  int          ack_cnt [0:1] = '{0, 0};
  logic [31:0] last_data [0:1] = '{32'd0, 32'd0};
  logic        last_err [0:1] = '{1'b0, 1'b0};
  int          ack_log[$];

  int   gp;
  int   lat;
  txn_t t;
  logic e_ack0, e_ack1, e_win;

  memory_arbiter #(.TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .p0_req_i    (p0_req),
    .p0_we_i     (p0_we),
    .p0_addr_i   (p0_addr),
    .p0_data_i   (p0_wdata),
    .p0_data_o   (p0_data),
    .p0_ack_o    (p0_ack),
    .p0_err_o    (p0_err),
    .p1_req_i    (p1_req),
    .p1_we_i     (p1_we),
    .p1_addr_i   (p1_addr),
    .p1_data_i   (p1_wdata),
    .p1_data_o   (p1_data),
    .p1_ack_o    (p1_ack),
    .p1_err_o    (p1_err),
    .mem_rd_en_o (mem_rd_en),
    .mem_wr_en_o (mem_wr_en),
    .mem_addr_o  (mem_addr),
    .mem_data_o  (mem_wdata),
    .mem_data_i  (mem_rdata),
    .mem_ack_i   (mem_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory: ack follows the enables by one cycle; data valid only with rd_en and ack.
  initial begin
    forever begin
      @(posedge clk);
      mem_ack <= ((mem_rd_en === 1'b1) || (mem_wr_en === 1'b1)) && !mem_noack;
    end
  end
  assign mem_rdata = (mem_rd_en && mem_ack) ? ram[mem_addr[9:2]] : 32'hA5A5_A5A5;

  // Per-cycle: compare against the model, record acks, drive requesters, arbitrate in the model.
  initial begin
    forever begin
      @(negedge clk);
      if (cyc == m_ack_cyc && !m_we_l) m_data[m_port] = m_rd_pend;
      e_ack0 = (cyc == m_ack_cyc) && (m_port == 0);
      e_ack1 = (cyc == m_ack_cyc) && (m_port == 1);
      e_win  = (cyc >= m_en_lo) && (cyc <= m_en_hi);
      check("p0_ack", {31'd0, p0_ack}, {31'd0, e_ack0});
      check("p1_ack", {31'd0, p1_ack}, {31'd0, e_ack1});
      check("p0_err", {31'd0, p0_err}, {31'd0, e_ack0 && m_err_pend});
      check("p1_err", {31'd0, p1_err}, {31'd0, e_ack1 && m_err_pend});
      check("p0_data", p0_data, m_data[0]);
      check("p1_data", p1_data, m_data[1]);
      check("mem_rd_en", {31'd0, mem_rd_en}, {31'd0, e_win && !m_we_l});
      check("mem_wr_en", {31'd0, mem_wr_en}, {31'd0, e_win && m_we_l});
      check("mem_addr", mem_addr, m_addr);
      check("mem_wdata", mem_wdata, m_wdata);
      check("both_enables", {31'd0, mem_rd_en && mem_wr_en}, 32'd0);
      check("both_acks", {31'd0, p0_ack && p1_ack}, 32'd0);

      if (p0_ack === 1'b1) begin
        last_data[0] = p0_data;
        last_err[0]  = p0_err;
        ack_cnt[0]++;
        ack_log.push_back(0);
        if (q0.size() != 0) void'(q0.pop_front());
      end
      if (p1_ack === 1'b1) begin
        last_data[1] = p1_data;
        last_err[1]  = p1_err;
        ack_cnt[1]++;
        ack_log.push_back(1);
        if (q1.size() != 0) void'(q1.pop_front());
      end
      if (mem_wr_en === 1'b1) ram[mem_addr[9:2]] = mem_wdata;

      if (rst_n === 1'b0) begin
        m_free     = cyc + 1;
        m_ack_cyc  = -1;
        m_en_lo    = -1;
        m_en_hi    = -2;
        m_last     = 1;
        m_we_l     = 1'b0;
        m_err_pend = 1'b0;
        m_addr     = 32'd0;
        m_wdata    = 32'd0;
        m_data[0]  = 32'd0;
        m_data[1]  = 32'd0;
        q0.delete();
        q1.delete();
      end

      p0_req = (q0.size() != 0);
      if (p0_req) begin
        p0_we = q0[0].we; p0_addr = q0[0].addr; p0_wdata = q0[0].wdata;
      end
      p1_req = (q1.size() != 0);
      if (p1_req) begin
        p1_we = q1[0].we; p1_addr = q1[0].addr; p1_wdata = q1[0].wdata;
      end

      if (rst_n === 1'b1 && cyc >= m_free && (p0_req || p1_req)) begin
        if (p0_req && p1_req) gp = (m_last == 1) ? 0 : 1;
        else gp = p1_req ? 1 : 0;
        t          = (gp == 0) ? q0[0] : q1[0];
        m_last     = gp;
        m_port     = gp;
        m_we_l     = t.we;
        m_addr     = t.addr;
        m_wdata    = t.wdata;
        lat        = mem_noack ? int'(TO) + 1 : 3;
        m_ack_cyc  = cyc + lat;
        m_en_lo    = cyc + 1;
        m_en_hi    = cyc + lat - 1;
        m_free     = cyc + lat + 1;
        m_err_pend = mem_noack;
        m_rd_pend  = mem_noack ? 32'd0 : m_mem[t.addr[9:2]];
        if (t.we) m_mem[t.addr[9:2]] = t.wdata;
      end
      cyc++;
    end
  end

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while ((q0.size() != 0 || q1.size() != 0 || cyc < m_free) && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("idle_wait_expired", (k >= budget) ? 32'd1 : 32'd0, 32'd0);
  endtask

  task automatic push(input int port, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    txn_t x;
    x.we = we; x.addr = addr; x.wdata = wdata;
    if (port == 0) q0.push_back(x);
    else q1.push_back(x);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vt [0:6];
    int   n_before;
    int   exp_order [0:5];

    for (int i = 0; i < 256; i++) begin
      ram[i]   = 32'hC0DE_0000 | 32'(i);
      m_mem[i] = 32'hC0DE_0000 | 32'(i);
    end
    ram[64]   = 32'hDEAD_BEEF;
    m_mem[64] = 32'hDEAD_BEEF;

    vt[0] = '{0, 1'b0, 32'h100, 32'h0,         1'b1, 32'hDEAD_BEEF};
    vt[1] = '{1, 1'b1, 32'h040, 32'h1234_5678, 1'b0, 32'h0};
    vt[2] = '{1, 1'b0, 32'h040, 32'h0,         1'b1, 32'h1234_5678};
    vt[3] = '{0, 1'b1, 32'h080, 32'hCAFE_F00D, 1'b0, 32'h0};
    vt[4] = '{1, 1'b0, 32'h080, 32'h0,         1'b1, 32'hCAFE_F00D};
    vt[5] = '{0, 1'b0, 32'h3FC, 32'h0,         1'b1, 32'hC0DE_00FF};
    vt[6] = '{1, 1'b0, 32'h000, 32'h0,         1'b1, 32'hC0DE_0000};

    tick(3);
    rst_n = 1'b1;
    tick(1);
    check("reset_rd_en", {31'd0, mem_rd_en}, 32'd0);
    check("reset_addr", mem_addr, 32'd0);
    check("reset_p0_data", p0_data, 32'd0);

    // Table-driven single transactions.
    for (int i = 0; i < 7; i++) begin
      n_before = ack_cnt[vt[i].port];
      push(vt[i].port, vt[i].we, vt[i].addr, vt[i].wdata);
      wait_idle(100);
      check("vec_ack_count", 32'(ack_cnt[vt[i].port]), 32'(n_before + 1));
      check("vec_err", {31'd0, last_err[vt[i].port]}, 32'd0);
      if (vt[i].chk_data) check("vec_data", last_data[vt[i].port], vt[i].exp_data);
    end

    // Back-to-back reads: second must return mem[0xC], not the stale word.
    push(0, 1'b0, 32'h8, 32'h0);
    push(0, 1'b0, 32'hC, 32'h0);
    wait_idle(100);
    check("stale_ack_data", last_data[0], 32'hC0DE_0003);

    // Watchdog: memory never acks.
    mem_noack = 1'b1;
    push(1, 1'b0, 32'h4, 32'h0);
    wait_idle(100);
    check("timeout_err", {31'd0, last_err[1]}, 32'd1);
    check("timeout_data", last_data[1], 32'd0);
    push(0, 1'b1, 32'h10, 32'h5555_AAAA);
    wait_idle(100);
    check("timeout_wr_err", {31'd0, last_err[0]}, 32'd1);
    mem_noack = 1'b0;
    push(1, 1'b0, 32'h4, 32'h0);
    wait_idle(100);
    check("after_timeout_err", {31'd0, last_err[1]}, 32'd0);
    check("after_timeout_data", last_data[1], 32'hC0DE_0001);

    // Reset in the middle of a p0 read, then both ports contend.
    ack_log.delete();
    push(0, 1'b0, 32'h100, 32'h0);
    tick(2);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    check("rst_mid_rd_en", {31'd0, mem_rd_en}, 32'd0);
    check("rst_mid_ack", {30'd0, p1_ack, p0_ack}, 32'd0);
    check("rst_mid_p0_data", p0_data, 32'd0);
    check("rst_mid_addr", mem_addr, 32'd0);
    for (int i = 0; i < 3; i++) begin
      push(0, 1'b0, 32'h0, 32'h0);
      push(1, 1'b0, 32'h4, 32'h0);
    end
    wait_idle(200);
    exp_order = '{0, 1, 0, 1, 0, 1};
    check("contention_ack_total", 32'(ack_log.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < ack_log.size()) check("contention_order", 32'(ack_log[i]), 32'(exp_order[i]));
    end
    check("contention_p0_data", last_data[0], 32'hC0DE_0000);
    check("contention_p1_data", last_data[1], 32'hC0DE_0001);

    // Randomized traffic against the model.
    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(0, 1) == 0 && q0.size() < 3)
        push(0, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)) << 2, $urandom);
      if ($urandom_range(0, 1) == 0 && q1.size() < 3)
        push(1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)) << 2, $urandom);
      tick($urandom_range(1, 6));
    end
    wait_idle(1000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
